// File: rtl/apb_modport.sv
// APB master FSM driving two 256x8 slaves.
// Bit 8 of the latched address picks the slave.
module apb_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic       pready,
  output logic [7:0] prdata,
  output logic       pslverr
);

  logic [7:0]   mem [256];
  logic [255:0] vld;
  logic         wr;

  assign wr     = psel & penable & pwrite;
  assign pready = psel & penable;

  // Valid flags clear on reset; set on a completed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (wr) begin
      vld[paddr] <= 1'b1;
    end
  end

  // Data storage is not reset; aborted writes never land.
  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem[paddr] <= pwdata;
    end
  end

  // Unwritten locations read as zero with an error.
  always_comb begin
    prdata  = vld[paddr] ? mem[paddr] : 8'h00;
    pslverr = psel & penable & ~pwrite & ~vld[paddr];
  end

endmodule

module apb_modport (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       transfer,
  input  logic       READ_WRITE,
  input  logic [8:0] apb_write_paddr,
  input  logic [8:0] apb_read_paddr,
  input  logic [7:0] apb_write_data,
  output logic [7:0] apb_read_data_out,
  output logic       PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t     state;
  logic       rw;
  logic [8:0] addr;
  logic [7:0] wdata;

  logic       psel1;
  logic       psel2;
  logic       penable;
  logic       pready1;
  logic       pready2;
  logic [7:0] prdata1;
  logic [7:0] prdata2;
  logic       perr1;
  logic       perr2;
  logic       pready;
  logic [7:0] prdata;
  logic       perr;

  assign psel1   = (state != IDLE) & ~addr[8];
  assign psel2   = (state != IDLE) & addr[8];
  assign penable = (state == ACCESS);

  assign pready = addr[8] ? pready2 : pready1;
  assign prdata = addr[8] ? prdata2 : prdata1;
  assign perr   = addr[8] ? perr2 : perr1;

  apb_slave u_slv1 (
    .clk    (PCLK),
    .rst    (PRESETn),
    .psel   (psel1),
    .penable(penable),
    .pwrite (~rw),
    .paddr  (addr[7:0]),
    .pwdata (wdata),
    .pready (pready1),
    .prdata (prdata1),
    .pslverr(perr1)
  );

  apb_slave u_slv2 (
    .clk    (PCLK),
    .rst    (PRESETn),
    .psel   (psel2),
    .penable(penable),
    .pwrite (~rw),
    .paddr  (addr[7:0]),
    .pwdata (wdata),
    .pready (pready2),
    .prdata (prdata2),
    .pslverr(perr2)
  );

  // Master FSM; request fields latch on entry to SETUP.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state             <= IDLE;
      rw                <= 1'b0;
      addr              <= '0;
      wdata             <= '0;
      apb_read_data_out <= 8'h00;
      PSLVERR           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (transfer) begin
            state <= SETUP;
            rw    <= READ_WRITE;
            addr  <= READ_WRITE ? apb_read_paddr
                                : apb_write_paddr;
            wdata <= apb_write_data;
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            if (rw) begin
              apb_read_data_out <= prdata;
              PSLVERR           <= perr;
            end else begin
              PSLVERR <= 1'b0;
            end
            if (transfer) begin
              state <= SETUP;
              rw    <= READ_WRITE;
              addr  <= READ_WRITE ? apb_read_paddr
                                  : apb_write_paddr;
              wdata <= apb_write_data;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_modport.sv
// Directed bench for apb_modport.
// Hand-computed expectations checked with immediate assertions.
module tb_apb_modport;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       transfer = 1'b0;
  logic       READ_WRITE = 1'b0;
  logic [8:0] apb_write_paddr = '0;
  logic [8:0] apb_read_paddr = '0;
  logic [7:0] apb_write_data = '0;
  logic [7:0] apb_read_data_out;
  logic       PSLVERR;

  int errors = 0;
  int checks = 0;
  logic [7:0] mid_data;
  logic       mid_err;

  apb_modport dut (
    .PCLK             (PCLK),
    .PRESETn          (PRESETn),
    .transfer         (transfer),
    .READ_WRITE       (READ_WRITE),
    .apb_write_paddr  (apb_write_paddr),
    .apb_read_paddr   (apb_read_paddr),
    .apb_write_data   (apb_write_data),
    .apb_read_data_out(apb_read_data_out),
    .PSLVERR          (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic r, input logic [8:0] a,
                      input logic [7:0] d);
    @(negedge PCLK);
    transfer        = 1'b1;
    READ_WRITE      = r;
    apb_read_paddr  = r ? a : ~a;
    apb_write_paddr = r ? ~a : a;
    apb_write_data  = d;
    @(posedge PCLK);
    @(negedge PCLK);
    transfer        = 1'b0;
    READ_WRITE      = ~r;
    apb_read_paddr  = ~a;
    apb_write_paddr = ~a;
    apb_write_data  = ~d;
    @(posedge PCLK);
    #1;
    mid_data = apb_read_data_out;
    mid_err  = PSLVERR;
    @(posedge PCLK);
    #1;
  endtask

  task automatic bb(input logic r, input logic [8:0] a,
                    input logic [7:0] d);
    READ_WRITE      = r;
    apb_read_paddr  = r ? a : ~a;
    apb_write_paddr = r ? ~a : a;
    apb_write_data  = d;
  endtask

  initial begin
    PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_data", apb_read_data_out, 8'h00);
    chk("rst_err", PSLVERR, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b0;

    xfer(1'b0, 9'h012, 8'h5A);
    chk("wr012_data", apb_read_data_out, 8'h00);
    chk("wr012_err", PSLVERR, 1'b0);
    xfer(1'b1, 9'h012, 8'h00);
    chk("rd012_mid", mid_data, 8'h00);
    chk("rd012_data", apb_read_data_out, 8'h5A);
    chk("rd012_err", PSLVERR, 1'b0);

    xfer(1'b0, 9'h112, 8'hA5);
    chk("wr112_keep", apb_read_data_out, 8'h5A);
    xfer(1'b1, 9'h012, 8'h00);
    chk("rd012b_data", apb_read_data_out, 8'h5A);
    xfer(1'b1, 9'h112, 8'h00);
    chk("rd112_mid", mid_data, 8'h5A);
    chk("rd112_data", apb_read_data_out, 8'hA5);
    chk("rd112_err", PSLVERR, 1'b0);

    xfer(1'b1, 9'h0FF, 8'h00);
    chk("rd0ff_data", apb_read_data_out, 8'h00);
    chk("rd0ff_err", PSLVERR, 1'b1);
    xfer(1'b0, 9'h0FF, 8'h33);
    chk("wr0ff_data", apb_read_data_out, 8'h00);
    chk("wr0ff_err", PSLVERR, 1'b0);
    xfer(1'b1, 9'h0FF, 8'h00);
    chk("rd0ffb_data", apb_read_data_out, 8'h33);
    chk("rd0ffb_err", PSLVERR, 1'b0);

    @(negedge PCLK);
    transfer = 1'b1;
    bb(1'b0, 9'h030, 8'h11);
    @(posedge PCLK);
    @(negedge PCLK);
    bb(1'b0, 9'h031, 8'h22);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    bb(1'b0, 9'h132, 8'h33);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    bb(1'b0, 9'h033, 8'h44);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    bb(1'b1, 9'h030, 8'h00);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    transfer = 1'b0;
    bb(1'b0, 9'h1FF, 8'hEE);
    @(posedge PCLK);
    #1;
    chk("b2b_mid", apb_read_data_out, 8'h33);
    @(posedge PCLK);
    #1;
    chk("b2b_rd030", apb_read_data_out, 8'h11);
    chk("b2b_err", PSLVERR, 1'b0);
    xfer(1'b1, 9'h031, 8'h00);
    chk("rd031", apb_read_data_out, 8'h22);
    xfer(1'b1, 9'h132, 8'h00);
    chk("rd132", apb_read_data_out, 8'h33);
    xfer(1'b1, 9'h032, 8'h00);
    chk("rd032_err", PSLVERR, 1'b1);
    xfer(1'b1, 9'h033, 8'h00);
    chk("rd033", apb_read_data_out, 8'h44);
    chk("rd033_err", PSLVERR, 1'b0);

    @(negedge PCLK);
    transfer        = 1'b1;
    READ_WRITE      = 1'b0;
    apb_write_paddr = 9'h020;
    apb_write_data  = 8'h77;
    @(posedge PCLK);
    @(negedge PCLK);
    transfer = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    chk("abort_data", apb_read_data_out, 8'h00);
    chk("abort_err", PSLVERR, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b0;
    xfer(1'b1, 9'h020, 8'h00);
    chk("rd020_data", apb_read_data_out, 8'h00);
    chk("rd020_err", PSLVERR, 1'b1);
    xfer(1'b1, 9'h012, 8'h00);
    chk("rd012_clr", PSLVERR, 1'b1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
